// File: rtl/debug_pkg.sv
// Shared definitions for the debug frame transmitter.
// DEBUG_FRAME_CHECKSUM_EN appends a checksum byte to every frame.
package debug_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StSend = ST_SEND,
    StWait = ST_WAIT,
    StDone = ST_DONE
  } state_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

`ifdef DEBUG_FRAME_CHECKSUM_EN
  localparam bit CHECKSUM_EN = 1'b1;
`else
  localparam bit CHECKSUM_EN = 1'b0;
`endif

  // Header + data bytes (+ checksum byte when enabled).
  function automatic int unsigned frame_bytes(input int unsigned nb_data,
                                              input int unsigned n_words,
                                              input bit          with_cs);
    return 1 + n_words * (nb_data / 8) + int'(with_cs);
  endfunction

endpackage

// File: rtl/frame_byte_sel.sv
// Combinational data-byte picker: snapshot + data byte index -> byte.
module frame_byte_sel #(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned N_WORDS   = 3,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned IDX_W     = 4
) (
  input  logic [N_WORDS*NB_DATA-1:0] i_snapshot,
  input  logic [IDX_W-1:0]           i_index,
  output logic [7:0]                 o_byte
);

  localparam int unsigned BPW     = NB_DATA / 8;
  localparam int unsigned N_BYTES = N_WORDS * BPW;

  // Words go out in ascending order; MSB_FIRST only flips bytes within a word.
  function automatic int unsigned byte_offset(input int unsigned idx);
    int unsigned b;
    b = idx % BPW;
    if (MSB_FIRST) b = BPW - 1 - b;
    return (idx / BPW) * NB_DATA + b * 8;
  endfunction

  always_comb begin
    o_byte = '0;
    for (int unsigned i = 0; i < N_BYTES; i++) begin
      if (i_index == IDX_W'(i)) o_byte = i_snapshot[byte_offset(i) +: 8];
    end
  end

endmodule

// File: rtl/debug_frame_tx.sv
// Snapshots N_WORDS debug words and streams them as a framed byte sequence to uart_tx.
// DEBUG_FRAME_CHECKSUM_EN adds a trailing HEADER ^ data-bytes checksum byte.
module debug_frame_tx
  import debug_pkg::*;
#(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned N_WORDS   = 3,
  parameter logic [7:0]  HEADER    = HEADER_DEFAULT,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [N_WORDS*NB_DATA-1:0] i_words,
  input  logic                       i_tx_done_tick,
  output logic                       o_tx_start,
  output logic [7:0]                 o_tx_data,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int unsigned      FRAME_BYTES = frame_bytes(NB_DATA, N_WORDS, CHECKSUM_EN);
  localparam int unsigned      CNT_W       = $clog2(FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(FRAME_BYTES - 1);

  state_e                     r_state, w_state_next;
  logic [N_WORDS*NB_DATA-1:0] r_snap;
  logic [CNT_W-1:0]           r_cnt;
  logic [CNT_W-1:0]           w_data_idx;
  logic [7:0]                 w_data_byte;
  logic [7:0]                 w_byte;
`ifdef DEBUG_FRAME_CHECKSUM_EN
  logic [7:0]                 r_cs;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StSend;
      StSend:  w_state_next = StWait;
      StWait:  if (i_tx_done_tick) w_state_next = (r_cnt == LAST_IDX) ? StDone : StSend;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_snap <= '0;
      r_cnt  <= '0;
`ifdef DEBUG_FRAME_CHECKSUM_EN
      r_cs   <= '0;
`endif
    end else if (r_state == StIdle && i_start) begin
      r_snap <= i_words;
      r_cnt  <= '0;
`ifdef DEBUG_FRAME_CHECKSUM_EN
      r_cs   <= HEADER;
`endif
    end else if (r_state == StWait && i_tx_done_tick) begin
      r_cnt <= r_cnt + 1'b1;
`ifdef DEBUG_FRAME_CHECKSUM_EN
      // Header is excluded so the checksum byte is HEADER ^ data bytes.
      if (r_cnt != '0) r_cs <= r_cs ^ w_byte;
`endif
    end
  end

  assign w_data_idx = r_cnt - 1'b1;

  frame_byte_sel #(
    .NB_DATA  (NB_DATA),
    .N_WORDS  (N_WORDS),
    .MSB_FIRST(MSB_FIRST),
    .IDX_W    (CNT_W)
  ) u_byte_sel (
    .i_snapshot(r_snap),
    .i_index   (w_data_idx),
    .o_byte    (w_data_byte)
  );

  always_comb begin
    w_byte = w_data_byte;
    if (r_cnt == '0) w_byte = HEADER;
`ifdef DEBUG_FRAME_CHECKSUM_EN
    else if (r_cnt == LAST_IDX) w_byte = r_cs;
`endif
  end

  assign o_tx_start = (r_state == StSend);
  assign o_tx_data  = (r_state == StSend || r_state == StWait) ? w_byte : 8'h00;
  assign o_busy     = (r_state != StIdle);
  assign o_done     = (r_state == StDone);

endmodule

// File: doc/debug_frame_tx.md
Name: debug_frame_tx

Overview:
- Parametrised successor to the debug word-to-byte buffer that feeds the UART transmitter.
- On request, atomically snapshots N_WORDS debug words (e.g. PC, instruction, data-read), then streams them as one framed byte sequence to uart_tx.
- Frame is: header byte, then data bytes in a selectable byte order, then an optional checksum byte.
- Sits between top_mips debug outputs and uart_tx; replaces the fixed 32-bit, single-word path.

Parameters:
- NB_DATA, 32, width of each debug word; must be a multiple of 8.
- N_WORDS, 3, number of words per frame.
- HEADER, 8'hA5, first byte of every frame.
- MSB_FIRST, 0, per-word byte order: 0 = bits[7:0] first, 1 = top byte first.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset; asynchronous, active-high.
- i_start  in  1  frame request; sampled only in IDLE.
- i_words  in  N_WORDS*NB_DATA  flattened words; word 0 = bits[NB_DATA-1:0].
- i_tx_done_tick  in  1  uart_tx byte-complete pulse.
- o_tx_start  out  1  one-cycle start pulse to uart_tx.
- o_tx_data  out  8  byte to transmit.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse after the final byte completes.

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; snapshot, byte counter and checksum cleared.
- Frame length: FRAME_BYTES = 1 + N_WORDS*NB_DATA/8, plus 1 with the checksum. Byte counter width = $clog2(FRAME_BYTES+1).
- States: IDLE -> SEND -> WAIT -> (SEND | DONE) -> IDLE.
- IDLE:
  - On i_start=1 at edge k: latch i_words into the snapshot, clear the counter, set checksum = HEADER, go to SEND.
  - o_busy is high from cycle k+1.
- SEND (one cycle):
  - o_tx_start=1 and o_tx_data = current byte; go to WAIT.
  - The header byte's o_tx_start therefore appears in cycle k+1.
- WAIT:
  - o_tx_data held stable.
  - On i_tx_done_tick: increment the counter and XOR the sent data byte into the checksum.
  - If more bytes remain, go to SEND; the next o_tx_start appears the cycle after the tick. Otherwise go to DONE.
- DONE (one cycle): o_done=1, o_busy=1; then IDLE, where o_busy=0.
- Byte order:
  - Words are always sent in order 0..N_WORDS-1.
  - Within a word, MSB_FIRST selects the order; it never alters word order.
- Ignored events:
  - i_start outside IDLE, including during DONE; never re-latches the snapshot.
  - i_tx_done_tick in IDLE, SEND or DONE.
- Input changes: i_words changes after the latch edge do not affect the frame in flight.
- Reset mid-frame: immediate return to IDLE, outputs 0, no o_done, partial frame abandoned.
- Back-to-back: i_start held high restarts a new frame at the first IDLE cycle after DONE.

Optional Feature:
- Macro: DEBUG_FRAME_CHECKSUM_EN.
- Defined: after the last data byte, one extra byte is sent, equal to HEADER XOR all data bytes; FRAME_BYTES includes it.
- Undefined: no checksum byte and no checksum register; DONE follows the last data byte.

Decomposition:
- Shared package/include debug_pkg holds:
  - state encoding localparams (IDLE, SEND, WAIT, DONE);
  - default HEADER value;
  - a byte-count helper function.
- One natural sub-module: frame_byte_sel. It is combinational: snapshot + byte index + MSB_FIRST -> selected byte.

Test Plan:
- N_WORDS=2, NB_DATA=32, MSB_FIRST=0, words 0x11223344 and 0xDEADBEEF, tx_done returned 10 cycles after each start:
  - o_tx_data sequence is A5 44 33 22 11 EF BE AD DE.
  - o_done pulses once, the cycle after the 9th tick.
- Same stimulus with DEBUG_FRAME_CHECKSUM_EN defined -> 10th byte is 0xC3.
- Same stimulus with MSB_FIRST=1 -> sequence is A5 11 22 33 44 DE AD BE EF.
- Change i_words and pulse i_start during the frame -> bytes unchanged, no second frame, single o_done.
- Assert i_reset after the 3rd tick -> all outputs 0 at once, no o_done; a new i_start then sends a full frame starting with A5.
- Hold i_start high for 3 frames; inject tx_done while IDLE -> three identical frames, one IDLE cycle between them, stray tick ignored.
